// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if
//   Bundles every signal between the three video-RAM requesters, the
//   arbiter and the single-port video memory.
//   slave  : arbiter side (takes requests and mem_q, drives grants and mem_*)
//   master : requester / memory side (drives requests and mem_q)
//   Requesters: vid (scanout reads), cpu (AVR window), dma (fill/copy).
interface vram_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 8
);
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_gnt;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_wait;

  logic          dma_req;
  logic          dma_we;
  logic          dma_lock;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt;

  logic [DW-1:0] rd_data;
  logic          vid_rvalid;
  logic          cpu_rvalid;
  logic          dma_rvalid;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_q;

  modport slave (
    input  vid_req, vid_addr,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
    input  mem_q,
    output vid_gnt, cpu_gnt, cpu_wait, dma_gnt,
    output rd_data, vid_rvalid, cpu_rvalid, dma_rvalid,
    output mem_addr, mem_wdata, mem_we
  );

  modport master (
    output vid_req, vid_addr,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
    output mem_q,
    input  vid_gnt, cpu_gnt, cpu_wait, dma_gnt,
    input  rd_data, vid_rvalid, cpu_rvalid, dma_rvalid,
    input  mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter
//   Shares one single-port video RAM (1-cycle read latency) between VGA
//   scanout (vid), the AVR CPU window (cpu) and the fill/copy DMA (dma).
//   Video has priority, but after VID_BURST back-to-back video grants with
//   cpu/dma waiting, one cpu/dma access is forced in. cpu and dma share the
//   remaining slots round robin. A dma read with dma_lock reserves the next
//   cycle for dma so a read-modify-write cannot be split.
// Ports
//   clock    : system clock, all state on posedge
//   reset_n  : asynchronous reset, active low
//   bus      : vram_arbiter_if.slave (requests, grants, read return, memory)
module vram_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 8,
  parameter int VID_BURST = 8
) (
  input  logic            clock,
  input  logic            reset_n,
  vram_arbiter_if.slave   bus
);

  localparam logic [7:0] BURST_MAX = 8'(VID_BURST);

  typedef enum logic [1:0] {SRC_NONE, SRC_VID, SRC_CPU, SRC_DMA} src_e;
  typedef enum logic       {RR_CPU, RR_DMA} rr_e;

  src_e       win;
  rr_e        rr_last;
  logic [7:0] vid_run;
  logic       lock_pend;
  logic       vid_block;
  logic       vid_vld_p1;
  logic       cpu_vld_p1;
  logic       dma_vld_p1;

  // Arbitration: purely combinational on the current requests.
  always_comb begin
    win       = SRC_NONE;
    vid_block = (vid_run == BURST_MAX) && (bus.cpu_req || bus.dma_req);
    if (lock_pend && bus.dma_req)
      win = SRC_DMA;
    else if (bus.vid_req && !vid_block)
      win = SRC_VID;
    else if (bus.cpu_req && bus.dma_req)
      win = (rr_last == RR_CPU) ? SRC_DMA : SRC_CPU;
    else if (bus.cpu_req)
      win = SRC_CPU;
    else if (bus.dma_req)
      win = SRC_DMA;
  end

  // Memory port mux; an idle cycle drives zeros so the RAM sees no stale write.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_we    = 1'b0;
    unique case (win)
      SRC_VID: begin
        bus.mem_addr = bus.vid_addr;
      end
      SRC_CPU: begin
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
        bus.mem_we    = bus.cpu_we;
      end
      SRC_DMA: begin
        bus.mem_addr  = bus.dma_addr;
        bus.mem_wdata = bus.dma_wdata;
        bus.mem_we    = bus.dma_we;
      end
      default: ;
    endcase
  end

  assign bus.vid_gnt  = (win == SRC_VID);
  assign bus.cpu_gnt  = (win == SRC_CPU);
  assign bus.dma_gnt  = (win == SRC_DMA);
  assign bus.cpu_wait = bus.cpu_req && (win != SRC_CPU);

  // ---- stage p1: arbitration state and read-return flags ----
  // Reset drops any in-flight read's valid; requesters simply re-issue.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vid_run    <= 8'd0;
      rr_last    <= RR_DMA;
      lock_pend  <= 1'b0;
      vid_vld_p1 <= 1'b0;
      cpu_vld_p1 <= 1'b0;
      dma_vld_p1 <= 1'b0;
    end else begin
      // Saturating run length; any non-video cycle (grant or idle) resets it.
      if (win == SRC_VID)
        vid_run <= (vid_run == BURST_MAX) ? vid_run : vid_run + 8'd1;
      else
        vid_run <= 8'd0;

      if (win == SRC_CPU)
        rr_last <= RR_CPU;
      else if (win == SRC_DMA)
        rr_last <= RR_DMA;

      // Lock lives for exactly one cycle whether or not dma uses it.
      lock_pend  <= bus.dma_gnt && bus.dma_lock && !bus.dma_we;

      vid_vld_p1 <= bus.vid_gnt;
      cpu_vld_p1 <= bus.cpu_gnt && !bus.cpu_we;
      dma_vld_p1 <= bus.dma_gnt && !bus.dma_we;
    end
  end

  assign bus.vid_rvalid = vid_vld_p1;
  assign bus.cpu_rvalid = cpu_vld_p1;
  assign bus.dma_rvalid = dma_vld_p1;
  assign bus.rd_data    = bus.mem_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter
//   Bench for vram_arbiter: drives the three requesters, models the video RAM
//   and checks grants, memory port and read returns. Read returns are checked
//   by a scoreboard filled when a read grant is seen.
module tb_vram_arbiter;

  logic clock;
  logic reset_n;

  vram_arbiter_if #(.AW(16), .DW(8)) vif ();

  vram_arbiter #(.AW(16), .DW(8), .VID_BURST(8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (vif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Video RAM model: read-first, 1-cycle read latency.
  logic [7:0] wr_mem [int];
  always @(posedge clock) begin
    logic [7:0] rd;
    rd = wr_mem.exists(int'(vif.mem_addr)) ? wr_mem[int'(vif.mem_addr)] : init_val(vif.mem_addr);
    if (vif.mem_we) wr_mem[int'(vif.mem_addr)] = vif.mem_wdata;
    vif.mem_q <= rd;
  end

  // Scoreboard: reference memory built from what the requesters drove.
  typedef struct packed {
    logic [2:0] src;
    logic [7:0] data;
  } sb_t;
  sb_t        sb_q [$];
  logic [7:0] ref_mem [int];

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
  endfunction

  always @(negedge clock) begin
    sb_t e;
    logic [2:0] rv;
    rv = {vif.vid_rvalid, vif.cpu_rvalid, vif.dma_rvalid};
    if (!reset_n) begin
      sb_q.delete();
    end else begin
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("rv_src", 32'(rv), 32'(e.src));
        chk("rv_data", 32'(vif.rd_data), 32'(e.data));
      end else if (rv != 3'b000) begin
        chk("rv_spurious", 32'(rv), 32'd0);
      end
      if (vif.vid_gnt)
        sb_q.push_back('{src: 3'b100, data: ref_rd(vif.vid_addr)});
      if (vif.cpu_gnt) begin
        if (vif.cpu_we) ref_mem[int'(vif.cpu_addr)] = vif.cpu_wdata;
        else sb_q.push_back('{src: 3'b010, data: ref_rd(vif.cpu_addr)});
      end
      if (vif.dma_gnt) begin
        if (vif.dma_we) ref_mem[int'(vif.dma_addr)] = vif.dma_wdata;
        else sb_q.push_back('{src: 3'b001, data: ref_rd(vif.dma_addr)});
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    vif.vid_req   = 1'b0;
    vif.vid_addr  = '0;
    vif.cpu_req   = 1'b0;
    vif.cpu_we    = 1'b0;
    vif.cpu_addr  = '0;
    vif.cpu_wdata = '0;
    vif.dma_req   = 1'b0;
    vif.dma_we    = 1'b0;
    vif.dma_lock  = 1'b0;
    vif.dma_addr  = '0;
    vif.dma_wdata = '0;
  endtask

  function automatic logic [31:0] gnts();
    return 32'({vif.vid_gnt, vif.cpu_gnt, vif.dma_gnt});
  endfunction

  function automatic logic [31:0] rvs();
    return 32'({vif.vid_rvalid, vif.cpu_rvalid, vif.dma_rvalid});
  endfunction

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clock);
    #4;
    chk("rst_gnt", gnts(), 32'd0);
    chk("rst_rvalid", rvs(), 32'd0);
    chk("rst_mem_we", 32'(vif.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(vif.mem_addr), 32'd0);
    cyc();
    reset_n = 1'b1;
    #3;
    chk("idle_gnt", gnts(), 32'd0);

    // Lone cpu read
    cyc();
    vif.cpu_req = 1'b1; vif.cpu_we = 1'b0; vif.cpu_addr = 16'h0100;
    #3;
    chk("cpu_rd_gnt", gnts(), 32'b010);
    chk("cpu_rd_wait", 32'(vif.cpu_wait), 32'd0);
    chk("cpu_rd_addr", 32'(vif.mem_addr), 32'h0100);
    chk("cpu_rd_we", 32'(vif.mem_we), 32'd0);
    cyc();
    vif.cpu_req = 1'b0;
    #3;
    chk("cpu_rvalid", 32'(vif.cpu_rvalid), 32'd1);
    chk("cpu_rd_data", 32'(vif.rd_data), 32'(init_val(16'h0100)));

    // cpu write then read back
    cyc();
    vif.cpu_req = 1'b1; vif.cpu_we = 1'b1; vif.cpu_addr = 16'h0200; vif.cpu_wdata = 8'h3C;
    #3;
    chk("cpu_wr_we", 32'(vif.mem_we), 32'd1);
    chk("cpu_wr_data", 32'(vif.mem_wdata), 32'h3C);
    cyc();
    vif.cpu_we = 1'b0;
    #3;
    chk("cpu_wr_norv", rvs(), 32'd0);
    cyc();
    vif.cpu_req = 1'b0;
    #3;
    chk("cpu_wr_rb", 32'(vif.rd_data), 32'h3C);

    // Video burst with cpu waiting: 8 vid, 1 cpu, repeating
    cyc();
    vif.vid_req = 1'b1; vif.vid_addr = 16'h1000;
    vif.cpu_req = 1'b1; vif.cpu_we = 1'b0; vif.cpu_addr = 16'h0100;
    for (int i = 0; i < 27; i++) begin
      logic [2:0] eg;
      #3;
      eg = ((i % 9) < 8) ? 3'b100 : 3'b010;
      chk("burst_gnt", gnts(), 32'(eg));
      chk("burst_wait", 32'(vif.cpu_wait), 32'(eg == 3'b100));
      cyc();
    end
    idle_inputs();

    // Reset, then cpu and dma alternate starting with cpu
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    vif.cpu_req = 1'b1; vif.cpu_addr = 16'h0100;
    vif.dma_req = 1'b1; vif.dma_addr = 16'h0300;
    for (int i = 0; i < 6; i++) begin
      #3;
      chk("rr_gnt", gnts(), (i % 2 == 0) ? 32'b010 : 32'b001);
      cyc();
    end
    idle_inputs();

    // Locked dma read-modify-write beats video
    cyc();
    vif.dma_req = 1'b1; vif.dma_we = 1'b0; vif.dma_lock = 1'b1; vif.dma_addr = 16'h0400;
    #3;
    chk("rmw_rd_gnt", gnts(), 32'b001);
    cyc();
    vif.dma_we = 1'b1; vif.dma_lock = 1'b0; vif.dma_wdata = 8'h55;
    vif.vid_req = 1'b1; vif.vid_addr = 16'h1000;
    #3;
    chk("rmw_wr_gnt", gnts(), 32'b001);
    chk("rmw_wr_addr", 32'(vif.mem_addr), 32'h0400);
    chk("rmw_wr_data", 32'(vif.mem_wdata), 32'h55);
    chk("rmw_wr_we", 32'(vif.mem_we), 32'd1);
    cyc();
    vif.dma_req = 1'b0; vif.dma_we = 1'b0;
    #3;
    chk("rmw_vid_gnt", gnts(), 32'b100);
    cyc();
    vif.vid_req = 1'b0;
    vif.cpu_req = 1'b1; vif.cpu_addr = 16'h0400;
    cyc();
    vif.cpu_req = 1'b0;
    #3;
    chk("rmw_rb", 32'(vif.rd_data), 32'h55);

    // Lock is lost when dma does not use the reserved cycle
    cyc();
    vif.dma_req = 1'b1; vif.dma_lock = 1'b1; vif.dma_addr = 16'h0500;
    #3;
    chk("lock2_gnt", gnts(), 32'b001);
    cyc();
    vif.dma_req = 1'b0; vif.dma_lock = 1'b0;
    vif.vid_req = 1'b1;
    #3;
    chk("lock2_skip", gnts(), 32'b100);
    cyc();
    vif.dma_req = 1'b1;
    #3;
    chk("lock2_drop", gnts(), 32'b100);
    cyc();
    idle_inputs();

    // Reset while a cpu read is in flight
    cyc();
    vif.cpu_req = 1'b1; vif.cpu_addr = 16'h0100;
    #3;
    chk("rst_mid_gnt", gnts(), 32'b010);
    #2;
    reset_n = 1'b0;
    cyc();
    vif.cpu_req = 1'b0;
    #3;
    chk("rst_mid_rvalid", 32'(vif.cpu_rvalid), 32'd0);
    cyc();
    reset_n = 1'b1;
    vif.cpu_req = 1'b1; vif.cpu_addr = 16'h0200;
    #3;
    chk("rst_regrant", gnts(), 32'b010);
    cyc();
    vif.cpu_req = 1'b0;
    #3;
    chk("rst_regrant_data", 32'(vif.rd_data), 32'h3C);

    cyc();
    cyc();
    #3;
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
